muldiv_seq_ctrl: RTL and testbench
==================================

// Module: muldiv_seq_ctrl
// PURPOSE
//   Sequences the shared multiplier (fixed-latency) and iterative divider on behalf of EX.
//   Latches operands, drives start/annul handshakes and holds stallreq until the 64-bit product or
//   quotient/remainder is ready. Then issues a single hi/lo write toward MEM.
//   Sits between the EX decode of mult/multu/div/divu and the mul/div units.
// PARAMETERS
//   MUL_LAT   2   cycles from operands presented to mul_result valid (>=1)
//   CNT_W     3   latency counter width; must satisfy 2**CNT_W > MUL_LAT
// PORTS
//   clk         in   1   clock, rising edge
//   resetn      in   1   asynchronous, active-low reset
//   op_valid    in   1   EX holds a mult/multu/div/divu this cycle
//   op_kind     in   2   00 mult, 01 multu, 10 div, 11 divu
//   op_src1     in   32  rs value (dividend / multiplicand)
//   op_src2     in   32  rt value (divisor / multiplier)
//   flush       in   1   kill the in-flight operation
//   ex_hold     in   1   EX frozen by a stall source other than this block
//   mul_signed  out  1   to multiplier
//   mul_ina     out  32  to multiplier
//   mul_inb     out  32  to multiplier
//   mul_result  in   64  {hi,lo} from multiplier
//   div_start   out  1   to divider; held high until div_ready
//   div_signed  out  1   to divider
//   div_op1     out  32  to divider
//   div_op2     out  32  to divider
//   div_annul   out  1   one-cycle abort to divider
//   div_ready   in   1   divider result valid
//   div_result  in   64  {remainder,quotient} from divider
//   stallreq    out  1   freeze IF..EX
//   hilo_we     out  1   one-cycle hi/lo write strobe
//   hi_o        out  32  registered hi result
//   lo_o        out  32  registered lo result
//   busy        out  1   state != IDLE
// BEHAVIOUR
//   Reset (async, resetn=0): state=IDLE, cnt=0, operand/result regs=0; all outputs 0.
//   FSM states IDLE, MUL, DIV, DONE:
//   - IDLE: op_valid & ~flush latches src1/src2/kind/signed.
//     kind[1]=0 -> MUL with cnt=MUL_LAT-1.
//     kind[1]=1 & src2!=0 -> DIV.
//     kind[1]=1 & src2==0 -> DONE with hi=src1, lo=32'hFFFF_FFFF; divider not started.
//   - MUL: mul_* driven from the latched operands; cnt decrements each cycle.
//     At cnt==0, capture hi/lo=mul_result[63:32]/[31:0] and go to DONE.
//   - DIV: div_start=1 and div_op*/div_signed driven from the latches.
//     On div_ready=1, capture hi/lo=div_result[63:32]/[31:0] and go to DONE.
//   - DONE: hilo_we = ~ex_hold. Go to IDLE when ~ex_hold; stay in DONE otherwise.
//   - mul_*/div_op* are 0 outside MUL/DIV.
//   stallreq = (IDLE & op_valid & ~flush) | MUL | DIV. Combinational; low in DONE so EX advances.
//   Latency (ex_hold=0): mult ends with hilo_we in cycle MUL_LAT+1 after acceptance.
//     Divide by zero ends with hilo_we in the cycle after acceptance.
//     div ends with hilo_we in the cycle after div_ready.
//   Flush, highest priority, any state:
//   - MUL or DIV -> IDLE, no hilo_we, results unchanged.
//   - In DIV, div_annul=1 for that one cycle and div_start=0.
//   - DONE -> IDLE with hilo_we=0.
//   - IDLE: op_valid is ignored.
//   Simultaneous div_ready & flush: flush wins; the result is discarded.
//   op_src*/op_kind changes after acceptance are ignored; only the latched copies are used.
//   A new op_valid is not sampled until the FSM is back in IDLE.
//   hi_o/lo_o hold their value until the next capture.
// STRUCTURE
//   Shared package: state encoding (2-bit), op_kind constants (OP_MULT/MULTU/DIV/DIVU),
//   divide-by-zero lo constant.
//   One sub-module, muldiv_lat_cnt: a loadable CNT_W down-counter with a zero flag.
//   Everything else stays in this module.
// TESTING
//   1. mult, src1=-3, src2=5, MUL_LAT=2, mul model -> stallreq 3 cycles, then hilo_we=1 with
//      hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1.
//   2. divu, src1=100, src2=7, divider returns ready after 33 cycles -> div_start high until
//      ready, then hilo_we with hi=2, lo=14, div_annul never set.
//   3. div, src2=0 -> no div_start; next cycle hilo_we with hi=src1, lo=32'hFFFF_FFFF;
//      stallreq high 1 cycle.
//   4. flush in the 10th cycle of DIV -> div_annul pulse; IDLE next cycle; no hilo_we;
//      hi_o/lo_o unchanged.
//   5. ex_hold=1 for 3 cycles on DONE entry -> hilo_we stays 0 during the hold, then exactly one
//      pulse; no restart although op_valid stays 1.
//   6. resetn low mid-MUL -> all outputs 0 immediately (async); IDLE after release.

Source files
------------

// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared types and constants for the mul/div sequencer: FSM encoding,
// op_kind codes and the divide-by-zero result pattern.
package muldiv_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [1:0]  OP_MULT  = 2'b00;
   localparam logic [1:0]  OP_MULTU = 2'b01;
   localparam logic [1:0]  OP_DIV   = 2'b10;
   localparam logic [1:0]  OP_DIVU  = 2'b11;

   // lo value written when the divisor is zero (hi gets the dividend)
   localparam logic [31:0] DIV0_LO  = 32'hFFFF_FFFF;

   function automatic logic is_div_kind(input logic [1:0] kind);
      return kind[1];
   endfunction

   function automatic logic kind_is_signed(input logic [1:0] kind);
      return ~kind[0];
   endfunction

endpackage

// File: rtl/muldiv_lat_cnt.sv
// Loadable down-counter that times the fixed multiplier latency.
// Saturates at zero; zero flags the cycle the product is valid.
module muldiv_lat_cnt #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Sequences the shared multiplier and iterative divider for EX: latches operands,
// stalls the pipe until the 64-bit result is captured, then issues one hi/lo write.
module muldiv_seq_ctrl
   import muldiv_seq_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 2,
   parameter int CNT_W   = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        op_valid,
   input  logic [1:0]  op_kind,
   input  logic [31:0] op_src1,
   input  logic [31:0] op_src2,
   input  logic        flush,
   input  logic        ex_hold,
   output logic        mul_signed,
   output logic [31:0] mul_ina,
   output logic [31:0] mul_inb,
   input  logic [63:0] mul_result,
   output logic        div_start,
   output logic        div_signed,
   output logic [31:0] div_op1,
   output logic [31:0] div_op2,
   output logic        div_annul,
   input  logic        div_ready,
   input  logic [63:0] div_result,
   output logic        stallreq,
   output logic        hilo_we,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   state_t      state;
   logic [31:0] src1_q;
   logic [31:0] src2_q;
   logic        signed_q;
   logic        accept;
   logic        in_mul;
   logic        in_div;
   logic        cnt_load;
   logic        cnt_dec;
   logic        cnt_zero;

   assign accept   = (state == ST_IDLE) && op_valid && !flush;
   assign cnt_load = accept && !is_div_kind(op_kind);
   assign cnt_dec  = in_mul && !flush;

   muldiv_lat_cnt #(
      .CNT_W (CNT_W)
   ) u_lat_cnt (
      .clk      (clk),
      .resetn   (resetn),
      .load     (cnt_load),
      .load_val (CNT_W'(MUL_LAT - 1)),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // Flush overrides every transition; captures in MUL/DIV are dropped with it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         src1_q   <= '0;
         src2_q   <= '0;
         signed_q <= 1'b0;
         hi_o     <= '0;
         lo_o     <= '0;
      end else if (flush) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (op_valid) begin
                  src1_q   <= op_src1;
                  src2_q   <= op_src2;
                  signed_q <= kind_is_signed(op_kind);
                  if (!is_div_kind(op_kind)) begin
                     state <= ST_MUL;
                  end else if (op_src2 != '0) begin
                     state <= ST_DIV;
                  end else begin
                     hi_o  <= op_src1;
                     lo_o  <= DIV0_LO;
                     state <= ST_DONE;
                  end
               end
            end
            ST_MUL: begin
               if (cnt_zero) begin
                  hi_o  <= mul_result[63:32];
                  lo_o  <= mul_result[31:0];
                  state <= ST_DONE;
               end
            end
            ST_DIV: begin
               if (div_ready) begin
                  hi_o  <= div_result[63:32];
                  lo_o  <= div_result[31:0];
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!ex_hold) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Unit operands are zero outside their own state so idle units see no activity.
   always_comb begin
      in_mul     = (state == ST_MUL);
      in_div     = (state == ST_DIV);
      mul_signed = in_mul && signed_q;
      mul_ina    = in_mul ? src1_q : '0;
      mul_inb    = in_mul ? src2_q : '0;
      div_start  = in_div && !flush;
      div_annul  = in_div && flush;
      div_signed = in_div && signed_q;
      div_op1    = in_div ? src1_q : '0;
      div_op2    = in_div ? src2_q : '0;
      hilo_we    = (state == ST_DONE) && !ex_hold && !flush;
      stallreq   = accept || in_mul || in_div;
      busy       = (state != ST_IDLE);
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Bench for muldiv_seq_ctrl: behavioural mul/div units, a vector table of
// directed operations, hand-written flush/reset sequences and random operations.
module tb_muldiv_seq_ctrl;
   import muldiv_seq_ctrl_pkg::*;

   localparam int MUL_LAT = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        op_valid;
   logic [1:0]  op_kind;
   logic [31:0] op_src1;
   logic [31:0] op_src2;
   logic        flush;
   logic        ex_hold;
   logic        mul_signed;
   logic [31:0] mul_ina;
   logic [31:0] mul_inb;
   logic [63:0] mul_result;
   logic        div_start;
   logic        div_signed;
   logic [31:0] div_op1;
   logic [31:0] div_op2;
   logic        div_annul;
   logic        div_ready;
   logic [63:0] div_result;
   logic        stallreq;
   logic        hilo_we;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        busy;
   logic [1:0]  dbg_state;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] exp_q[$];
   logic [63:0] cur_hilo;
   int          div_lat;
   int          dcnt;

   typedef struct {
      logic [1:0]  kind;
      logic [31:0] a;
      logic [31:0] b;
      int          dlat;
      int          flush_at;
      int          hold_n;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[13];

   muldiv_seq_ctrl #(
      .MUL_LAT (MUL_LAT),
      .CNT_W   (3)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .op_valid   (op_valid),
      .op_kind    (op_kind),
      .op_src1    (op_src1),
      .op_src2    (op_src2),
      .flush      (flush),
      .ex_hold    (ex_hold),
      .mul_signed (mul_signed),
      .mul_ina    (mul_ina),
      .mul_inb    (mul_inb),
      .mul_result (mul_result),
      .div_start  (div_start),
      .div_signed (div_signed),
      .div_op1    (div_op1),
      .div_op2    (div_op2),
      .div_annul  (div_annul),
      .div_ready  (div_ready),
      .div_result (div_result),
      .stallreq   (stallreq),
      .hilo_we    (hilo_we),
      .hi_o       (hi_o),
      .lo_o       (lo_o),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   // Architectural result of one operation: {hi, lo}.
   function automatic logic [63:0] ref_result(input logic [1:0] kind, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint r;
      if (!kind[0]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      if (!kind[1]) return 64'(sa * sb);
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Cycle (0 = acceptance) in which the FSM first sits in DONE.
   function automatic int done_cycle(input logic [1:0] kind, input logic [31:0] b, input int dlat);
      if (!kind[1]) return MUL_LAT + 1;
      if (b == 32'd0) return 1;
      return dlat + 2;
   endfunction

   // Multiplier: combinational product of the presented operands.
   always_comb mul_result = ref_result({1'b0, !mul_signed}, mul_ina, mul_inb);

   // Divider: ready once div_start has been held for div_lat cycles; dropping start resets it.
   always_comb div_result = (div_op2 == 32'd0) ? 64'd0
                                               : ref_result({1'b1, !div_signed}, div_op1, div_op2);
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) dcnt <= 0;
      else if (div_start) dcnt <= dcnt + 1;
      else dcnt <= 0;
   end
   assign div_ready = (div_lat > 0) && (dcnt == div_lat);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Runs one operation; entered and left just after a rising edge.
   task automatic run_op(input logic [1:0] kind, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int dlat, input int flush_at,
                         input int hold_n);
      int  d_exp;
      int  we_cyc;
      bit  is_mul;
      bit  is_div;
      logic [63:0] sb_val;
      is_mul  = !kind[1];
      is_div  = kind[1] && (b != 32'd0);
      d_exp   = done_cycle(kind, b, dlat);
      we_cyc  = d_exp + hold_n;
      div_lat = dlat;
      if (!(flush_at >= 1 && flush_at <= we_cyc)) exp_q.push_back(exp);
      op_valid = 1'b1;
      op_kind  = kind;
      op_src1  = a;
      op_src2  = b;
      flush    = 1'b0;
      ex_hold  = 1'b0;
      @(negedge clk);
      chk("accept_stall", 64'(stallreq), 64'd1);
      chk("accept_we", 64'(hilo_we), 64'd0);
      @(posedge clk); #1;
      if (d_exp == 1) cur_hilo = exp;
      op_src1 = $urandom;
      op_src2 = $urandom;
      op_kind = 2'($urandom_range(0, 3));
      for (int cyc = 1; cyc <= we_cyc; cyc++) begin
         flush   = (cyc == flush_at);
         ex_hold = (cyc >= d_exp) && (cyc < we_cyc);
         @(negedge clk);
         chk("stallreq", 64'(stallreq), 64'(cyc < d_exp));
         chk("hilo_we", 64'(hilo_we), 64'((cyc == we_cyc) && !flush));
         chk("div_start", 64'(div_start), 64'(is_div && (cyc < d_exp) && !flush));
         chk("div_annul", 64'(div_annul), 64'(is_div && (cyc < d_exp) && flush));
         chk("mul_ina", 64'(mul_ina), 64'((is_mul && cyc < d_exp) ? a : 32'd0));
         chk("div_op2", 64'(div_op2), 64'((is_div && cyc < d_exp) ? b : 32'd0));
         chk("hilo_hold", {hi_o, lo_o}, cur_hilo);
         if (hilo_we) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_we", 64'd1, 64'd0);
            end else begin
               sb_val = exp_q.pop_front();
               chk("sb_hilo", {hi_o, lo_o}, sb_val);
            end
         end
         @(posedge clk); #1;
         if (cyc == d_exp - 1 && !flush) cur_hilo = exp;
         if (flush) break;
      end
      op_valid = 1'b0;
      flush    = 1'b0;
      ex_hold  = 1'b0;
      @(negedge clk);
      chk("idle_after", 64'(busy), 64'd0);
      chk("idle_stall", 64'(stallreq), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  r_kind;
      logic [31:0] r_a;
      logic [31:0] r_b;
      int          r_dlat;
      int          r_hold;
      int          r_flush;

      vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,        1,  -1, 0, 64'hFFFF_FFFF_FFFF_FFF1};
      vecs[1]  = '{OP_DIVU,  32'd100,       32'd7,        33, -1, 0, 64'h0000_0002_0000_000E};
      vecs[2]  = '{OP_DIV,   32'h1234_5678, 32'd0,        1,  -1, 0, 64'h1234_5678_FFFF_FFFF};
      vecs[3]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, -1, 0, 64'hFFFF_FFFE_0000_0001};
      vecs[4]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        5,  -1, 0, 64'hFFFF_FFFF_FFFF_FFFD};
      vecs[5]  = '{OP_DIVU,  32'hFFFF_FFF9, 32'd2,        3,  -1, 0, 64'h0000_0001_7FFF_FFFC};
      vecs[6]  = '{OP_MULT,  32'h0001_0000, 32'h0001_0000, 1, -1, 3, 64'h0000_0001_0000_0000};
      vecs[7]  = '{OP_DIVU,  32'd100,       32'd7,        33, 10, 0, 64'h0000_0002_0000_000E};
      vecs[8]  = '{OP_DIV,   32'd50,        32'd7,        4,  5,  0, 64'h0000_0001_0000_0007};
      vecs[9]  = '{OP_MULT,  32'd3,         32'd4,        1,  2,  0, 64'h0000_0000_0000_000C};
      vecs[10] = '{OP_MULTU, 32'd3,         32'd4,        1,  4,  2, 64'h0000_0000_0000_000C};
      vecs[11] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 2, -1, 0, 64'h0000_0000_8000_0000};
      vecs[12] = '{OP_DIVU,  32'hDEAD_BEEF, 32'd0,        1,  -1, 1, 64'hDEAD_BEEF_FFFF_FFFF};

      resetn   = 1'b0;
      op_valid = 1'b0;
      op_kind  = 2'b00;
      op_src1  = '0;
      op_src2  = '0;
      flush    = 1'b0;
      ex_hold  = 1'b0;
      div_lat  = 0;
      cur_hilo = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", 64'({stallreq, hilo_we, busy, div_start, div_annul, mul_signed, div_signed}),
          64'd0);
      chk("rst_hilo", {hi_o, lo_o}, 64'd0);
      chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      resetn = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         run_op(vecs[i].kind, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].dlat,
                vecs[i].flush_at, vecs[i].hold_n);
      end

      // Flush on the acceptance cycle: the op must not start.
      op_valid = 1'b1;
      op_kind  = OP_MULT;
      op_src1  = 32'd9;
      op_src2  = 32'd9;
      flush    = 1'b1;
      @(negedge clk);
      chk("flush_idle_stall", 64'(stallreq), 64'd0);
      @(posedge clk); #1;
      op_valid = 1'b0;
      flush    = 1'b0;
      @(negedge clk);
      chk("flush_idle_busy", 64'(busy), 64'd0);
      chk("flush_idle_hilo", {hi_o, lo_o}, cur_hilo);
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a multiply.
      op_valid = 1'b1;
      op_kind  = OP_MULT;
      op_src1  = 32'd7;
      op_src2  = 32'd9;
      @(posedge clk); #1;
      op_valid = 1'b0;
      #1;
      chk("pre_rst_mul_ina", 64'(mul_ina), 64'd7);
      chk("pre_rst_stall", 64'(stallreq), 64'd1);
      resetn = 1'b0;
      #1;
      chk("async_rst_ctrl", 64'({stallreq, hilo_we, busy, div_start, mul_signed}), 64'd0);
      chk("async_rst_mul_ina", 64'(mul_ina), 64'd0);
      chk("async_rst_hilo", {hi_o, lo_o}, 64'd0);
      cur_hilo = '0;
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;

      for (int n = 0; n < 40; n++) begin
         r_kind = 2'($urandom_range(0, 3));
         r_a    = $urandom;
         r_b    = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 1) == 1) r_b = r_b >> $urandom_range(0, 28);
         r_dlat = $urandom_range(1, 8);
         r_hold = $urandom_range(0, 3);
         r_flush = ($urandom_range(0, 4) == 0)
                   ? $urandom_range(1, done_cycle(r_kind, r_b, r_dlat) + r_hold) : -1;
         run_op(r_kind, r_a, r_b, ref_result(r_kind, r_a, r_b), r_dlat, r_flush, r_hold);
      end

      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
